// File: rtl/mollusc_issue_pkg.sv
// rtl/mollusc_issue_pkg.sv - shared types and constants for the issue stage
package mollusc_issue_pkg;

    localparam int NREGS     = 16;
    localparam int ADDR_W    = 4;
    localparam int PAYLOAD_W = 29;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        FAULT = 2'd2
    } state_t;

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [ADDR_W-1:0]    ra_a;
        logic [ADDR_W-1:0]    ra_b;
        logic [ADDR_W-1:0]    ra_m;
        logic [ADDR_W-1:0]    ra_d;
        logic [2:0]           src_use;
        logic                 wr;
        logic                 priv_req;
    } entry_t;

    function automatic logic [NREGS-1:0] reg_onehot(input logic [ADDR_W-1:0] addr);
        return NREGS'(1) << addr;
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - register busy scoreboard; ISSUE_WB_BYPASS_EN masks same-cycle writebacks from lookups
module issue_scoreboard
    import mollusc_issue_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] look_a,
    input  logic [ADDR_W-1:0] look_b,
    input  logic [ADDR_W-1:0] look_m,
    input  logic [ADDR_W-1:0] look_d,
    output logic              hit_a,
    output logic              hit_b,
    output logic              hit_m,
    output logic              hit_d
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;
    logic [NREGS-1:0] busy_view;

    always_comb begin
        set_mask = set_en ? reg_onehot(set_addr) : '0;
        clr_mask = clr_en ? reg_onehot(clr_addr) : '0;
        // set is OR-ed after the clear so an issue to the same register wins
        busy_d   = (busy_q & ~clr_mask) | set_mask;
`ifdef ISSUE_WB_BYPASS_EN
        busy_view = busy_q & ~clr_mask;
`else
        busy_view = busy_q;
`endif
        hit_a = busy_view[look_a];
        hit_b = busy_view[look_b];
        hit_m = busy_view[look_m];
        hit_d = busy_view[look_d];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - single-entry issue stage with hazard and privilege checks (option: ISSUE_WB_BYPASS_EN)
module issue_ctrl
    import mollusc_issue_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [ADDR_W-1:0]    in_ra_a,
    input  logic [ADDR_W-1:0]    in_ra_b,
    input  logic [ADDR_W-1:0]    in_ra_m,
    input  logic [ADDR_W-1:0]    in_ra_d,
    input  logic [2:0]           in_use,
    input  logic                 in_wr,
    input  logic                 in_priv_req,
    input  logic                 priv_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [ADDR_W-1:0]    out_ra_a,
    output logic [ADDR_W-1:0]    out_ra_b,
    output logic [ADDR_W-1:0]    out_ra_m,
    output logic [ADDR_W-1:0]    out_ra_d,
    output logic [2:0]           out_use,
    output logic                 out_wr,
    input  logic                 wb_valid,
    input  logic [ADDR_W-1:0]    wb_addr,
    input  logic                 flush,
    output logic                 fault_valid,
    output logic [PAYLOAD_W-1:0] fault_payload,
    input  logic                 fault_ack
);

    state_t state_q, state_d;
    entry_t entry_q, entry_d;
    entry_t in_entry;

    logic hit_a, hit_b, hit_m, hit_d;
    logic hazard, bad, issue, accept;

    issue_scoreboard u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issue & entry_q.wr),
        .set_addr (entry_q.ra_d),
        .clr_en   (wb_valid),
        .clr_addr (wb_addr),
        .look_a   (entry_q.ra_a),
        .look_b   (entry_q.ra_b),
        .look_m   (entry_q.ra_m),
        .look_d   (entry_q.ra_d),
        .hit_a    (hit_a),
        .hit_b    (hit_b),
        .hit_m    (hit_m),
        .hit_d    (hit_d)
    );

    always_comb begin
        in_entry = '{payload: in_payload, ra_a: in_ra_a, ra_b: in_ra_b, ra_m: in_ra_m,
                     ra_d: in_ra_d, src_use: in_use, wr: in_wr, priv_req: in_priv_req};

        hazard = (entry_q.src_use[0] & hit_a) | (entry_q.src_use[1] & hit_b) |
                 (entry_q.src_use[2] & hit_m) | (entry_q.wr & hit_d);
        bad    = entry_q.priv_req & ~priv_in;

        // flush suppresses issue, so execute never sees a handshake for a discarded entry
        out_valid = (state_q == HOLD) & ~hazard & ~bad & ~flush;
        issue     = out_valid & out_ready;
        in_ready  = ~flush & ((state_q == IDLE) | issue);
        accept    = in_valid & in_ready;

        state_d = state_q;
        entry_d = entry_q;
        if (flush) begin
            state_d = IDLE;
            entry_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = HOLD;
                        entry_d = in_entry;
                    end
                end
                HOLD: begin
                    if (bad) begin
                        state_d = FAULT;
                    end else if (accept) begin
                        entry_d = in_entry;
                    end else if (issue) begin
                        state_d = IDLE;
                    end
                end
                FAULT: begin
                    if (fault_ack) begin
                        state_d = IDLE;
                        entry_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    entry_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            entry_q <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
        end
    end

    assign out_payload   = entry_q.payload;
    assign out_ra_a      = entry_q.ra_a;
    assign out_ra_b      = entry_q.ra_b;
    assign out_ra_m      = entry_q.ra_m;
    assign out_ra_d      = entry_q.ra_d;
    assign out_use       = entry_q.src_use;
    assign out_wr        = entry_q.wr;
    assign fault_valid   = (state_q == FAULT);
    assign fault_payload = entry_q.payload;

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
Single-entry issue stage between the decoder and execute. It holds one decoded instruction and tracks pending register writes in a 16-entry busy scoreboard. It issues only when no RAW or WAW hazard exists and the privilege check passes. Privilege violations are diverted to a fault handshake instead of issuing.

Parameters:
NREGS, 16, architectural registers tracked (power of two)
ADDR_W, 4, register address width (log2 NREGS)
PAYLOAD_W, 29, opaque instruction payload carried with the entry

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
in_valid  in  1  decoded instruction offered
in_ready  out  1  entry accepted when in_valid & in_ready
in_payload  in  PAYLOAD_W  raw instruction word
in_ra_a / in_ra_b / in_ra_m / in_ra_d  in  ADDR_W each  source A, B, M and destination addresses
in_use  in  3  {m,b,a} source-used flags
in_wr  in  1  instruction writes ra_d
in_priv_req  in  1  instruction touches a privileged register
priv_in  in  1  current mode is privileged
out_valid  out  1  issue valid
out_ready  in  1  execute accepts
out_payload / out_ra_a / out_ra_b / out_ra_m / out_ra_d / out_use / out_wr  out  as inputs  registered copy of the held entry
wb_valid  in  1  writeback retiring
wb_addr  in  ADDR_W  register being written back
flush  in  1  discard held entry
fault_valid  out  1  privilege fault pending
fault_payload  out  PAYLOAD_W  faulting instruction
fault_ack  in  1  fault consumed

Behaviour:
- States: IDLE (no entry), HOLD (entry held), FAULT (faulting entry held).
- Reset: state=IDLE, busy=0, all entry fields=0, out_valid=0, fault_valid=0, in_ready=1 once rst deasserts.
- in_ready = IDLE | (HOLD & issue). Back-to-back accept and issue gives 1 instr/cycle.
- Accept: latch all in_* fields and go to HOLD. Latency from accept to out_valid is 1 cycle.
- In HOLD:
  - hazard = (use[a] & busy[ra_a]) | (use[b] & busy[ra_b]) | (use[m] & busy[ra_m]) | (wr & busy[ra_d]).
  - bad = priv_req & ~priv_in. priv_in is sampled live while in HOLD.
  - out_valid = ~hazard & ~bad.
  - issue = out_valid & out_ready.
  - On issue with wr: set busy[ra_d]. Go to IDLE, or stay in HOLD if a new entry is accepted the same cycle.
  - bad → FAULT next cycle, no issue. busy is unchanged.
- FAULT: fault_valid=1, fault_payload held, in_ready=0. fault_ack → IDLE.
- Writeback: wb_valid clears busy[wb_addr] at the clock edge.
  - wb and an issue-set to the same register in one cycle: the set wins, busy stays 1.
  - wb to a non-busy register: no effect, no error.
- Without bypass, a register cleared by wb is visible to the hazard check the following cycle.
- out_valid may drop only when state changes. Once out_valid is asserted with out_ready=0, the entry fields are held stable until issue.
- flush: highest priority over accept and issue. It clears the held entry and FAULT state (→ IDLE, fault_valid=0) and blocks accept that cycle. busy bits are NOT cleared, because in-flight writebacks still arrive.
- rst mid-operation: returns to the reset state in one cycle, and all busy bits are cleared.

Optional Feature:
Macro: ISSUE_WB_BYPASS_EN
- Defined: the hazard check uses busy & ~(wb_valid one-hot of wb_addr). A writeback in the same cycle releases a dependent instruction immediately (0-cycle RAW release).
- Undefined: the hazard check uses registered busy only (1-cycle release). No combinational path exists from wb_* to out_valid.

Decomposition:
- Package mollusc_issue_pkg: state enum (IDLE/HOLD/FAULT), NREGS/ADDR_W constants, an entry struct {payload, ra_a, ra_b, ra_m, ra_d, use, wr, priv_req}.
- One sub-module, issue_scoreboard: busy vector with set port, clear port, set-wins rule, and three source lookups plus one destination lookup.

Test Plan:
- Reset, then accept {wr=1, ra_d=3}, out_ready=1 → out_valid in cycle 1, busy[3]=1.
- Next instr uses ra_a=3 → out_valid=0. wb_valid, wb_addr=3 → issues 1 cycle later; issues the same cycle with ISSUE_WB_BYPASS_EN defined.
- Issue writing r5 plus wb_addr=5 in the same cycle → busy[5]=1 afterward.
- in_priv_req=1, priv_in=0 → no out_valid, fault_valid=1 with the payload, in_ready=0. fault_ack → IDLE, in_ready=1.
- 4 independent instrs back-to-back, out_ready=1 → 4 issues in 4 cycles. Then out_ready=0 → out_* held stable.
- flush while in HOLD with busy[7]=1 → IDLE next cycle, busy[7] still 1. rst → busy all 0.
